// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command path: frame FSM encoding, framing constants
// and the address field that downstream command consumers decode.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CHECK   = 2'd2
  } state_e;

  localparam logic [7:0] DefaultHeader = 8'hAA;

  // Header + four payload bytes + checksum.
  localparam int unsigned FrameBytes   = 6;
  localparam int unsigned PayloadBytes = FrameBytes - 2;

  // Address field of a command word, compared by the address-decoded consumers.
  localparam int unsigned AddrMsb = 31;
  localparam int unsigned AddrLsb = 16;

  function automatic logic [AddrMsb-AddrLsb:0] cmd_addr(input logic [31:0] word);
    return word[AddrMsb:AddrLsb];
  endfunction

endpackage

// File: rtl/idle_timeout_counter.sv
// Idle-cycle counter with clear/enable and a terminal-count flag; saturates at the
// terminal value so the flag stays asserted until the owner clears it.
module idle_timeout_counter #(
  parameter int unsigned Width    = 24,
  parameter int unsigned Terminal = 99999
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [Width-1:0] TermCount = Width'(Terminal);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TermCount);

endmodule

// File: rtl/uart_frame_assembler.sv
// Assembles header / 4-byte payload / XOR checksum frames from the UART byte stream into
// validated 32-bit command words, with inter-byte timeout recovery.
module uart_frame_assembler
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  HEADER         = DefaultHeader,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] uart_reg,
  output logic        uart_ready,
  output logic        frame_err,
  output logic        timeout_err,
  output logic        busy
);

  localparam logic [1:0] LastIdx = 2'(PayloadBytes - 1);

  state_e      state_q, state_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  csum_q, csum_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] uart_reg_q, uart_reg_d;
  logic        ready_q, ready_d;
  logic        ferr_q, ferr_d;
  logic        terr_q, terr_d;
  logic        busy_q;

  logic in_frame;
  logic idle_tc;
  logic timed_out;

  assign in_frame  = (state_q != S_HUNT);
  // An arriving byte always beats the timeout in the same cycle.
  assign timed_out = in_frame && idle_tc && !rx_valid;

  idle_timeout_counter #(
    .Width    (24),
    .Terminal (TIMEOUT_CYCLES - 1)
  ) u_idle_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!in_frame || rx_valid),
    .en_i  (in_frame),
    .tc_o  (idle_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (timed_out) begin
      state_d = S_HUNT;
    end else if (rx_valid) begin
      case (state_q)
        S_HUNT: begin
          if (rx_data == HEADER) begin
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (idx_q == LastIdx) begin
            state_d = S_CHECK;
          end
        end
        S_CHECK: state_d = S_HUNT;
        default: state_d = S_HUNT;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    shadow_d   = shadow_q;
    csum_d     = csum_q;
    idx_d      = idx_q;
    uart_reg_d = uart_reg_q;
    ready_d    = 1'b0;
    ferr_d     = 1'b0;
    terr_d     = 1'b0;
    if (timed_out) begin
      terr_d   = 1'b1;
      shadow_d = '0;
      csum_d   = '0;
      idx_d    = '0;
    end else if (rx_valid) begin
      case (state_q)
        S_HUNT: begin
          if (rx_data == HEADER) begin
            idx_d  = '0;
            csum_d = '0;
          end
        end
        S_PAYLOAD: begin
          // A header-valued byte here is payload, not a restart.
          shadow_d = {shadow_q[23:0], rx_data};
          csum_d   = csum_q ^ rx_data;
          idx_d    = idx_q + 2'd1;
        end
        S_CHECK: begin
          if (rx_data == csum_q) begin
            uart_reg_d = shadow_q;
            ready_d    = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: begin
          idx_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q   <= '0;
      csum_q     <= '0;
      idx_q      <= '0;
      uart_reg_q <= '0;
      ready_q    <= 1'b0;
      ferr_q     <= 1'b0;
      terr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      csum_q     <= csum_d;
      idx_q      <= idx_d;
      uart_reg_q <= uart_reg_d;
      ready_q    <= ready_d;
      ferr_q     <= ferr_d;
      terr_q     <= terr_d;
      busy_q     <= (state_d != S_HUNT);
    end
  end

  assign uart_reg    = uart_reg_q;
  assign uart_ready  = ready_q;
  assign frame_err   = ferr_q;
  assign timeout_err = terr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed self-checking bench for uart_frame_assembler (TIMEOUT_CYCLES = 16).
module tb_uart_frame_assembler;

  localparam logic [7:0] Hdr = 8'hAA;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] uart_reg;
  logic        uart_ready;
  logic        frame_err;
  logic        timeout_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse bookkeeping, sampled on the falling edge.
  int   cyc = 0;
  int   n_ready = 0;
  int   n_ferr = 0;
  int   n_terr = 0;
  int   n_dbl = 0;
  int   ready_at = 0;
  int   prev_ready_at = 0;
  logic ready_last = 1'b0;

  uart_frame_assembler #(
    .HEADER         (Hdr),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .uart_reg    (uart_reg),
    .uart_ready  (uart_ready),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (uart_ready) begin
      n_ready       <= n_ready + 1;
      prev_ready_at <= ready_at;
      ready_at      <= cyc;
    end
    if (frame_err)   n_ferr <= n_ferr + 1;
    if (timeout_err) n_terr <= n_terr + 1;
    if (uart_ready && ready_last) n_dbl <= n_dbl + 1;
    ready_last <= uart_ready;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; presents one byte for exactly one rising edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] w, input logic [7:0] csum);
    send(Hdr);
    send(w[31:24]);
    send(w[23:16]);
    send(w[15:8]);
    send(w[7:0]);
    send(csum);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, f0, t0, seen;
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("reset uart_reg", uart_reg, 32'h0);
    check_eq("reset uart_ready", {31'b0, uart_ready}, 32'h0);
    check_eq("reset frame_err", {31'b0, frame_err}, 32'h0);
    check_eq("reset timeout_err", {31'b0, timeout_err}, 32'h0);
    check_eq("reset busy", {31'b0, busy}, 32'h0);
    idle(2);

    // Good frame: DA^C1^12^34 = 3D
    r0 = n_ready; f0 = n_ferr;
    send(Hdr);
    check_eq("busy after header", {31'b0, busy}, 32'h1);
    send(8'hDA); send(8'hC1); send(8'h12); send(8'h34); send(8'h3D);
    idle(2);
    check_eq("good ready count", n_ready - r0, 1);
    check_eq("good no frame_err", n_ferr - f0, 0);
    check_eq("good uart_reg", uart_reg, 32'hDAC11234);
    check_eq("good busy idle", {31'b0, busy}, 32'h0);

    // Bad checksum then a good frame: 01^02^03^04 = 04
    r0 = n_ready; f0 = n_ferr;
    send_frame(32'hDAC11234, 8'h3E);
    idle(2);
    check_eq("bad frame_err count", n_ferr - f0, 1);
    check_eq("bad no ready", n_ready - r0, 0);
    check_eq("bad uart_reg held", uart_reg, 32'hDAC11234);
    send_frame(32'h01020304, 8'h04);
    idle(2);
    check_eq("after bad uart_reg", uart_reg, 32'h01020304);

    // Leading garbage, header value inside payload
    r0 = n_ready; f0 = n_ferr;
    send(8'h00); send(8'hFF); send(8'hAA); send(8'hAA);
    send(8'h00); send(8'h00); send(8'h01); send(8'hAB);
    idle(2);
    check_eq("garbage uart_reg", uart_reg, 32'hAA000001);
    check_eq("garbage ready count", n_ready - r0, 1);
    check_eq("garbage no frame_err", n_ferr - f0, 0);

    // Timeout on idle clock 16
    t0 = n_terr;
    send(Hdr); send(8'h12);
    seen = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (timeout_err && seen == 0) seen = i;
    end
    check_eq("timeout idle clock", seen, 16);
    check_eq("timeout count", n_terr - t0, 1);
    check_eq("timeout busy", {31'b0, busy}, 32'h0);
    send_frame(32'h00000005, 8'h05);
    idle(2);
    check_eq("post-timeout uart_reg", uart_reg, 32'h00000005);

    // Byte on idle clock 16 wins: 12^34^56^78 = 08
    r0 = n_ready; t0 = n_terr;
    send(Hdr); send(8'h12);
    idle(15);
    send(8'h34); send(8'h56); send(8'h78); send(8'h08);
    idle(20);
    check_eq("race no timeout", n_terr - t0, 0);
    check_eq("race ready count", n_ready - r0, 1);
    check_eq("race uart_reg", uart_reg, 32'h12345678);

    // Back-to-back frames: 0A^0B^0C^0D = 00, 11^22^33^44 = 44
    r0 = n_ready;
    send_frame(32'h0A0B0C0D, 8'h00);
    send_frame(32'h11223344, 8'h44);
    idle(2);
    check_eq("b2b ready count", n_ready - r0, 2);
    check_eq("b2b spacing", ready_at - prev_ready_at, 6);
    check_eq("b2b uart_reg", uart_reg, 32'h11223344);

    // Reset after three payload bytes: 5A^5A^00^01 = 01
    t0 = n_terr; f0 = n_ferr;
    send(Hdr); send(8'h01); send(8'h02); send(8'h03);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst uart_reg", uart_reg, 32'h0);
    check_eq("midrst busy", {31'b0, busy}, 32'h0);
    check_eq("midrst ready", {31'b0, uart_ready}, 32'h0);
    idle(20);
    check_eq("midrst no timeout", n_terr - t0, 0);
    check_eq("midrst no frame_err", n_ferr - f0, 0);
    send_frame(32'h5A5A0001, 8'h01);
    idle(2);
    check_eq("midrst next uart_reg", uart_reg, 32'h5A5A0001);
    check_eq("ready never doubled", n_dbl, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
